ram_burst_tracker: RTL and testbench

//  Sequencer behind ram_sampler. Consumes the per-RAM-clock sampled bus (filter_* + filter_strobe),

---
 rtl/ram_burst_tracker.sv | 156 +++++++++++++++
 tb/tb_ram_burst_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_tracker.sv
// ram_burst_tracker
//   Sequencer behind ram_sampler. Follows synchronous RAM burst accesses from the
//   per-RAM-clock sampled bus: address latch, then a latency wait, then data beats.
//   It emits one event per data word, carrying the reconstructed word address.
//   The output is a single-entry valid/ready register. A beat that arrives while
//   that register is still occupied is dropped and counted.
//
//   Optional build macro: RAM_TRACE_WRAP32_EN
//     When defined, the burst address wraps inside an aligned 32-word block.
//     When undefined, the burst address increments linearly modulo 2^ADDR_W.
//
// Ports
//   mclk, reset_n        system clock; asynchronous active-low reset
//   filter_a/d/ublb      sampled address, data and byte enables {ub,lb}
//   filter_read/write    sampled read / write qualifiers
//   filter_addr_latch    sampled address-latch qualifier
//   filter_strobe        1-mclk pulse marking a new RAM-clock sample
//   cfg_latency          RAM clocks from address latch to first data beat
//   ev_valid/ev_ready    event handshake
//   ev_addr/data/ublb    event payload
//   ev_write             1 = write beat, 0 = read beat
//   drop_count           saturating count of events lost to back-pressure
//   overflow             sticky flag: at least one event was dropped
module ram_burst_tracker #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LAT_W  = 4,
  parameter int unsigned DROP_W = 16
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] filter_a,
  input  logic [DATA_W-1:0] filter_d,
  input  logic [1:0]        filter_ublb,
  input  logic              filter_read,
  input  logic              filter_write,
  input  logic              filter_addr_latch,
  input  logic              filter_strobe,
  input  logic [LAT_W-1:0]  cfg_latency,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [ADDR_W-1:0] ev_addr,
  output logic [DATA_W-1:0] ev_data,
  output logic [1:0]        ev_ublb,
  output logic              ev_write,
  output logic [DROP_W-1:0] drop_count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LAT_W-1:0]  cnt;

  logic              access_c;
  logic              emit_c;
  logic              slot_free_c;
  logic [ADDR_W-1:0] next_addr_c;
  logic [LAT_W-1:0]  lat_load_c;

  // Decode the current strobe: whether it carries a data beat that must be emitted.
  always_comb begin
    access_c    = filter_read | filter_write;
    emit_c      = 1'b0;
    slot_free_c = ~ev_valid | ev_ready;
    // A latency of 0 behaves like a latency of 1 (first beat on the first access strobe).
    lat_load_c  = (cfg_latency == LAT_W'(0)) ? LAT_W'(1) : cfg_latency;
    if (filter_strobe && !filter_addr_latch && access_c) begin
      case (state)
        ST_WAIT:  emit_c = (cnt == LAT_W'(1));
        ST_BURST: emit_c = 1'b1;
        default:  emit_c = 1'b0;
      endcase
    end
  end

  // Burst address successor.
  always_comb begin
`ifdef RAM_TRACE_WRAP32_EN
    next_addr_c = {cur_addr[ADDR_W-1:5], 5'(cur_addr[4:0] + 5'd1)};
`else
    next_addr_c = cur_addr + ADDR_W'(1);
`endif
  end

  // Burst sequencer, output register and drop accounting.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      cnt        <= '0;
      ev_valid   <= 1'b0;
      ev_addr    <= '0;
      ev_data    <= '0;
      ev_ublb    <= '0;
      ev_write   <= 1'b0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      // The consumer takes the held event; a same-cycle emit below reloads it.
      if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end

      if (filter_strobe) begin
        if (filter_addr_latch) begin
          cur_addr <= filter_a;
          cnt      <= lat_load_c;
          state    <= ST_WAIT;
        end else begin
          case (state)
            ST_WAIT: begin
              if (!access_c) begin
                state <= ST_IDLE;
              end else if (cnt == LAT_W'(1)) begin
                state <= ST_BURST;
              end else begin
                cnt <= cnt - LAT_W'(1);
              end
            end
            ST_BURST: begin
              if (!access_c) begin
                state <= ST_IDLE;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end

      // Emit: load the output register when it is free, otherwise drop the beat.
      // The burst address advances in both cases.
      if (emit_c) begin
        cur_addr <= next_addr_c;
        if (slot_free_c) begin
          ev_valid <= 1'b1;
          ev_addr  <= cur_addr;
          ev_data  <= filter_d;
          ev_ublb  <= filter_ublb;
          ev_write <= filter_write;
        end else begin
          overflow <= 1'b1;
          if (drop_count != {DROP_W{1'b1}}) begin
            drop_count <= drop_count + DROP_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_tracker.sv
// Directed testbench for ram_burst_tracker. Inputs are driven on the falling edge
// and outputs are checked on the following falling edge. That places each check
// one mclk after the strobe it follows.
module tb_ram_burst_tracker;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LAT_W  = 4;
  localparam int unsigned DROP_W = 16;

  logic              mclk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] filter_a;
  logic [DATA_W-1:0] filter_d;
  logic [1:0]        filter_ublb;
  logic              filter_read;
  logic              filter_write;
  logic              filter_addr_latch;
  logic              filter_strobe;
  logic [LAT_W-1:0]  cfg_latency;
  logic              ev_valid;
  logic              ev_ready;
  logic [ADDR_W-1:0] ev_addr;
  logic [DATA_W-1:0] ev_data;
  logic [1:0]        ev_ublb;
  logic              ev_write;
  logic [DROP_W-1:0] drop_count;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  ram_burst_tracker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT_W(LAT_W), .DROP_W(DROP_W)
  ) dut (
    .mclk(mclk),
    .reset_n(reset_n),
    .filter_a(filter_a),
    .filter_d(filter_d),
    .filter_ublb(filter_ublb),
    .filter_read(filter_read),
    .filter_write(filter_write),
    .filter_addr_latch(filter_addr_latch),
    .filter_strobe(filter_strobe),
    .cfg_latency(cfg_latency),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_addr(ev_addr),
    .ev_data(ev_data),
    .ev_ublb(ev_ublb),
    .ev_write(ev_write),
    .drop_count(drop_count),
    .overflow(overflow)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One strobe cycle starting at a falling edge. It returns on the next falling
  // edge, when the registered result of that strobe is visible.
  task automatic strobe(input logic latch, input logic rd, input logic wr,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [1:0] ublb);
    filter_addr_latch = latch;
    filter_read       = rd;
    filter_write      = wr;
    filter_a          = a;
    filter_d          = d;
    filter_ublb       = ublb;
    filter_strobe     = 1'b1;
    @(negedge mclk);
    filter_strobe     = 1'b0;
    filter_addr_latch = 1'b0;
    filter_read       = 1'b0;
    filter_write      = 1'b0;
  endtask

  // Advance to the next falling edge with no strobe. With ev_ready=1 this lets
  // the consumer take a pending event.
  task automatic idle();
    @(negedge mclk);
  endtask

  initial begin
    reset_n = 1'b0;
    filter_a = '0; filter_d = '0; filter_ublb = '0;
    filter_read = 1'b0; filter_write = 1'b0; filter_addr_latch = 1'b0;
    filter_strobe = 1'b0; cfg_latency = '0; ev_ready = 1'b1;

    #1;
    chk("rst_valid",    32'(ev_valid), 32'd0);
    chk("rst_addr",     32'(ev_addr), 32'd0);
    chk("rst_drop",     32'(drop_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
    idle();

    // Latency 3: the first two access strobes are wait states.
    cfg_latency = 4'd3;
    strobe(1'b1, 1'b0, 1'b0, 23'h000100, 16'h0000, 2'b00);
    chk("lat_latch_noev", 32'(ev_valid), 32'd0);
    cfg_latency = 4'd7;  // a change after the latch must not affect this burst
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h1111, 2'b11);
    chk("lat_w1_noev", 32'(ev_valid), 32'd0);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h2222, 2'b11);
    chk("lat_w2_noev", 32'(ev_valid), 32'd0);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h3333, 2'b11);
    chk("lat_b0_valid", 32'(ev_valid), 32'd1);
    chk("lat_b0_addr",  32'(ev_addr), 32'h100);
    chk("lat_b0_data",  32'(ev_data), 32'h3333);
    chk("lat_b0_write", 32'(ev_write), 32'd0);
    idle();
    chk("lat_b0_taken", 32'(ev_valid), 32'd0);
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h4444, 2'b10);
    chk("lat_b1_addr",  32'(ev_addr), 32'h101);
    chk("lat_b1_data",  32'(ev_data), 32'h4444);
    chk("lat_b1_ublb",  32'(ev_ublb), 32'h2);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h5555, 2'b11);
    chk("lat_b2_valid", 32'(ev_valid), 32'd1);
    chk("lat_b2_addr",  32'(ev_addr), 32'h102);
    chk("lat_b2_data",  32'(ev_data), 32'h5555);
    idle();

    // Latency 0, address wrap at the top of the space, then termination.
    cfg_latency = 4'd0;
    strobe(1'b1, 1'b0, 1'b0, 23'h7FFFFF, 16'h0000, 2'b00);
    idle();
    strobe(1'b0, 1'b0, 1'b1, 23'h0, 16'hAAAA, 2'b01);
    chk("z_b0_valid", 32'(ev_valid), 32'd1);
    chk("z_b0_addr",  32'(ev_addr), 32'h7FFFFF);
    chk("z_b0_write", 32'(ev_write), 32'd1);
    chk("z_b0_ublb",  32'(ev_ublb), 32'h1);
    idle();
    strobe(1'b0, 1'b1, 1'b1, 23'h0, 16'hBBBB, 2'b11);  // read+write: write wins
`ifdef RAM_TRACE_WRAP32_EN
    chk("z_b1_addr",  32'(ev_addr), 32'h7FFFE0);
`else
    chk("z_b1_addr",  32'(ev_addr), 32'h000000);
`endif
    chk("z_b1_write", 32'(ev_write), 32'd1);
    chk("z_b1_data",  32'(ev_data), 32'hBBBB);
    idle();
    strobe(1'b0, 1'b0, 1'b0, 23'h0, 16'h0000, 2'b00);
    chk("z_term_noev", 32'(ev_valid), 32'd0);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hCCCC, 2'b11);
    chk("z_after_term_noev", 32'(ev_valid), 32'd0);
    idle();

    // Restart: a new latch during the wait abandons the first burst.
    cfg_latency = 4'd2;
    strobe(1'b1, 1'b0, 1'b0, 23'h000200, 16'h0000, 2'b00);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hD001, 2'b11);
    chk("rs_w_noev", 32'(ev_valid), 32'd0);
    idle();
    strobe(1'b1, 1'b0, 1'b0, 23'h000300, 16'h0000, 2'b00);
    chk("rs_latch_noev", 32'(ev_valid), 32'd0);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hD002, 2'b11);
    chk("rs_w2_noev", 32'(ev_valid), 32'd0);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hD003, 2'b11);
    chk("rs_b0_valid", 32'(ev_valid), 32'd1);
    chk("rs_b0_addr",  32'(ev_addr), 32'h300);
    idle();

    // Burst crossing a 32-word boundary.
    cfg_latency = 4'd1;
    strobe(1'b1, 1'b0, 1'b0, 23'h00003E, 16'h0000, 2'b00);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hE000, 2'b11);
    chk("wr_b0_addr", 32'(ev_addr), 32'h3E);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hE001, 2'b11);
    chk("wr_b1_addr", 32'(ev_addr), 32'h3F);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hE002, 2'b11);
`ifdef RAM_TRACE_WRAP32_EN
    chk("wr_b2_addr", 32'(ev_addr), 32'h20);
`else
    chk("wr_b2_addr", 32'(ev_addr), 32'h40);
`endif
    idle();

    // Back-pressure: the first beat is held and the next three are dropped.
    ev_ready = 1'b0;
    strobe(1'b1, 1'b0, 1'b0, 23'h000400, 16'h0000, 2'b00);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0A01, 2'b11);
    chk("bp_b0_valid", 32'(ev_valid), 32'd1);
    chk("bp_b0_addr",  32'(ev_addr), 32'h400);
    chk("bp_ovf_pre",  32'(overflow), 32'd0);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0A02, 2'b11);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0A03, 2'b11);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0A04, 2'b11);
    chk("bp_hold_valid", 32'(ev_valid), 32'd1);
    chk("bp_hold_addr",  32'(ev_addr), 32'h400);
    chk("bp_hold_data",  32'(ev_data), 32'h0A01);
    chk("bp_drop",       32'(drop_count), 32'd3);
    chk("bp_overflow",   32'(overflow), 32'd1);
    ev_ready = 1'b1;
    idle();
    ev_ready = 1'b0;
    chk("bp_accept_valid", 32'(ev_valid), 32'd0);
    chk("bp_drop_kept",    32'(drop_count), 32'd3);

    // Reset in the middle of a burst while an event is held.
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0A05, 2'b11);
    chk("rb_valid",    32'(ev_valid), 32'd1);
    chk("rb_addr",     32'(ev_addr), 32'h404);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rm_valid",    32'(ev_valid), 32'd0);
    chk("rm_drop",     32'(drop_count), 32'd0);
    chk("rm_overflow", 32'(overflow), 32'd0);
    chk("rm_addr",     32'(ev_addr), 32'd0);
    @(negedge mclk);
    reset_n  = 1'b1;
    ev_ready = 1'b1;
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0B01, 2'b11);
    chk("rp_rd1_noev", 32'(ev_valid), 32'd0);
    idle();
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0B02, 2'b11);
    chk("rp_rd2_noev", 32'(ev_valid), 32'd0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
